// File: rtl/line_drawer_arbiter.sv
// Round-robin arbiter that lets two requesters share a single line drawer.
// Each requester gets a one-deep capture buffer. Its ready output stays low until the drawer finishes that line.
module line_drawer_arbiter #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS),
    localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_start,
    input  logic [X_WIDTH-1:0] req0_x1,
    input  logic [X_WIDTH-1:0] req0_x2,
    input  logic [Y_WIDTH-1:0] req0_y1,
    input  logic [Y_WIDTH-1:0] req0_y2,
    output logic               req0_ready,
    input  logic               req1_start,
    input  logic [X_WIDTH-1:0] req1_x1,
    input  logic [X_WIDTH-1:0] req1_x2,
    input  logic [Y_WIDTH-1:0] req1_y1,
    input  logic [Y_WIDTH-1:0] req1_y2,
    output logic               req1_ready,
    output logic [X_WIDTH-1:0] ld_x1,
    output logic [X_WIDTH-1:0] ld_x2,
    output logic [Y_WIDTH-1:0] ld_y1,
    output logic [Y_WIDTH-1:0] ld_y2,
    output logic               ld_start,
    input  logic               ld_ready,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE_WAIT, DRAW_WAIT} state_t;

    state_t             state, state_nxt;
    logic [1:0]         pending;
    logic [1:0]         req_start;
    logic [X_WIDTH-1:0] in_x1 [2];
    logic [X_WIDTH-1:0] in_x2 [2];
    logic [Y_WIDTH-1:0] in_y1 [2];
    logic [Y_WIDTH-1:0] in_y2 [2];
    logic [X_WIDTH-1:0] cap_x1 [2];
    logic [X_WIDTH-1:0] cap_x2 [2];
    logic [Y_WIDTH-1:0] cap_y1 [2];
    logic [Y_WIDTH-1:0] cap_y2 [2];
    logic               last_grant;
    logic               grant;
    logic               sel;
    logic               issue;
    logic               retire;

    assign req_start = {req1_start, req0_start};
    assign in_x1[0]  = req0_x1;
    assign in_x1[1]  = req1_x1;
    assign in_x2[0]  = req0_x2;
    assign in_x2[1]  = req1_x2;
    assign in_y1[0]  = req0_y1;
    assign in_y1[1]  = req1_y1;
    assign in_y2[0]  = req0_y2;
    assign in_y2[1]  = req1_y2;

    assign req0_ready = !pending[0];
    assign req1_ready = !pending[1];
    assign busy       = (state != IDLE) || (|pending);

    // When both are pending, the requester that was not served last wins.
    assign sel = (&pending) ? ~last_grant : pending[1];

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                if (ld_ready && (|pending)) begin
                    issue     = 1'b1;
                    state_nxt = ISSUE_WAIT;
                end
            end
            ISSUE_WAIT: state_nxt = DRAW_WAIT;
            DRAW_WAIT: begin
                if (ld_ready) begin
                    retire    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A start pulse is accepted only while the slot is free, so a busy requester cannot overwrite its own capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            for (int i = 0; i < 2; i++) begin
                cap_x1[i] <= '0;
                cap_x2[i] <= '0;
                cap_y1[i] <= '0;
                cap_y2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (retire && (grant == 1'(i))) begin
                    pending[i] <= 1'b0;
                end else if (req_start[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    cap_x1[i]  <= in_x1[i];
                    cap_x2[i]  <= in_x2[i];
                    cap_y1[i]  <= in_y1[i];
                    cap_y2[i]  <= in_y2[i];
                end
            end
        end
    end

    // Drawer coordinates load only on a grant, which holds them stable until the next grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_start   <= 1'b0;
            ld_x1      <= '0;
            ld_x2      <= '0;
            ld_y1      <= '0;
            ld_y2      <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            ld_start <= issue;
            if (issue) begin
                grant <= sel;
                ld_x1 <= cap_x1[sel];
                ld_x2 <= cap_x2[sel];
                ld_y1 <= cap_y1[sel];
                ld_y2 <= cap_y2[sel];
            end
            if (retire) last_grant <= grant;
        end
    end

endmodule
